// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the instruction/data memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INSTR,
    OWN_DATA
  } mem_owner_e;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] start,
                                         input logic [ADDR_W-1:0] mask);
    return (addr & ~mask) == start;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; grants are combinational, only the
// last-granted requester is held in a flop.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a_c,
  output logic gnt_b_c
);

  // 1 = requester b was granted last, so a wins the next tie
  logic rr_last;

  always_comb begin
    gnt_a_c = req_a & (~req_b | rr_last);
    gnt_b_c = req_b & (~req_a | ~rr_last);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b1;
    end else if (gnt_a_c) begin
      rr_last <= 1'b0;
    end else if (gnt_b_c) begin
      rr_last <= 1'b1;
    end
  end

endmodule

// File: rtl/ibex_mem_arb.sv
// Arbitrates Ibex instruction-fetch and data ports onto one single-port RAM
// with 1-cycle read latency, routing responses and flagging out-of-range accesses.
module ibex_mem_arb
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE  = 65536,
  parameter logic [31:0] MEM_START = 32'h0000_0000
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        instr_req,
  input  logic [31:0] instr_addr,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [31:0] MEM_MASK = 32'(MEM_SIZE - 1);

  obi_req_t   instr_bus, data_bus, sel;
  logic       in_range;
  mem_owner_e rsp_owner_q, rsp_owner_d;
  logic       rsp_err_q, rsp_err_d;
  logic       rsp_we_q, rsp_we_d;

  // Requests are masked during reset so no grant can escape
  always_comb begin
    instr_bus = '{req: instr_req & rst_sys_n, we: 1'b0, be: 4'hF,
                  addr: instr_addr, wdata: '0};
    data_bus  = '{req: data_req & rst_sys_n, we: data_we, be: data_be,
                  addr: data_addr, wdata: data_wdata};
  end

  rr_arb2 u_rr_arb2 (
    .clk     (clk_sys),
    .rst_n   (rst_sys_n),
    .req_a   (instr_bus.req),
    .req_b   (data_bus.req),
    .gnt_a_c (instr_gnt),
    .gnt_b_c (data_gnt)
  );

  // Granted request drives the RAM only when it decodes into the RAM window
  always_comb begin
    sel = '0;
    if (instr_gnt) begin
      sel = instr_bus;
    end else if (data_gnt) begin
      sel = data_bus;
    end
    in_range  = addr_in_range(sel.addr, MEM_START, MEM_MASK);
    mem_req   = sel.req & in_range;
    mem_we    = mem_req & sel.we;
    mem_be    = mem_req ? sel.be : 4'h0;
    mem_addr  = mem_req ? ((sel.addr & MEM_MASK) >> 2) : 32'h0;
    mem_wdata = mem_req ? sel.wdata : 32'h0;
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      rsp_owner_q <= OWN_NONE;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_owner_q <= rsp_owner_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  always_comb begin
    rsp_owner_d = OWN_NONE;
    rsp_err_d   = 1'b0;
    rsp_we_d    = 1'b0;
    if (instr_gnt) begin
      rsp_owner_d = OWN_INSTR;
    end else if (data_gnt) begin
      rsp_owner_d = OWN_DATA;
    end
    if (sel.req) begin
      rsp_err_d = ~in_range;
      rsp_we_d  = sel.we;
    end
  end

  // Stores and errored accesses return zero data
  always_comb begin
    instr_rvalid = rsp_owner_q == OWN_INSTR;
    data_rvalid  = rsp_owner_q == OWN_DATA;
    instr_err    = instr_rvalid & rsp_err_q;
    data_err     = data_rvalid & rsp_err_q;
    instr_rdata  = (instr_rvalid && !rsp_err_q) ? mem_rdata : 32'h0;
    data_rdata   = (data_rvalid && !rsp_err_q && !rsp_we_q) ? mem_rdata : 32'h0;
  end

`ifndef SYNTHESIS
  a_one_gnt : assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    !(instr_gnt && data_gnt));
  a_one_rvalid : assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    !(instr_rvalid && data_rvalid));
  a_instr_rvalid : assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    instr_rvalid |-> $past(instr_gnt));
  a_data_rvalid : assert property (@(posedge clk_sys) disable iff (!rst_sys_n)
    data_rvalid |-> $past(data_gnt));
`endif

endmodule

// File: tb/tb_ibex_mem_arb.sv
// Directed bench for ibex_mem_arb: per-cycle vector table plus a reset-mid-access sequence.
module tb_ibex_mem_arb;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_we, data_gnt, data_rvalid, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  ibex_mem_arb #(.MEM_SIZE(65536), .MEM_START(32'h0)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata), .data_err(data_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Simple single-port RAM, 16K words, 1-cycle read latency
  logic [31:0] ram [0:16383];
  always @(posedge clk_sys) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) ram[mem_addr[13:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= ram[mem_addr[13:0]];
      end
    end
  end

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [3:0]  dbe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        igt;
    logic        dgt;
    logic        mreq;
    logic [31:0] maddr;
    logic        irv;
    logic [31:0] irdata;
    logic        ierr;
    logic        drv;
    logic [31:0] drdata;
    logic        derr;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    instr_req = 1'b0; instr_addr = 32'h0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0;
    data_addr = 32'h0; data_wdata = 32'h0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) ram[i] = 32'h0;
    ram[14'h40] = 32'hDEAD_BEEF;

    //          ireq iaddr     dreq we be     daddr         dwdata        igt dgt mreq maddr   irv irdata        ierr drv drdata       derr
    vecs[0]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        0, 0, 32'h0,        0};
    vecs[1]  = '{1, 32'h100, 0, 0, 4'h0, 32'h0,     32'h0,        1, 0, 1, 32'h40, 0, 32'h0,        0, 0, 32'h0,        0};
    vecs[2]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 32'h0,  1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    vecs[3]  = '{0, 32'h0,   1, 1, 4'h3, 32'h200,   32'h12345678, 0, 1, 1, 32'h80, 0, 32'h0,        0, 0, 32'h0,        0};
    vecs[4]  = '{0, 32'h0,   1, 0, 4'hF, 32'h200,   32'h0,        0, 1, 1, 32'h80, 0, 32'h0,        0, 1, 32'h0,        0};
    vecs[5]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        0, 1, 32'h5678,     0};
    vecs[6]  = '{0, 32'h0,   1, 0, 4'hF, 32'h10000, 32'h0,        0, 1, 0, 32'h0,  0, 32'h0,        0, 0, 32'h0,        0};
    vecs[7]  = '{0, 32'h0,   0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        0, 1, 32'h0,        1};
    vecs[8]  = '{1, 32'h100, 1, 0, 4'hF, 32'h200,   32'h0,        1, 0, 1, 32'h40, 0, 32'h0,        0, 0, 32'h0,        0};
    vecs[9]  = '{1, 32'h100, 1, 0, 4'hF, 32'h200,   32'h0,        0, 1, 1, 32'h80, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    vecs[10] = '{1, 32'h100, 1, 0, 4'hF, 32'h200,   32'h0,        1, 0, 1, 32'h40, 0, 32'h0,        0, 1, 32'h5678,     0};
    vecs[11] = '{1, 32'h100, 1, 0, 4'hF, 32'h200,   32'h0,        0, 1, 1, 32'h80, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    vecs[12] = '{1, 32'h100, 1, 0, 4'hF, 32'h200,   32'h0,        1, 0, 1, 32'h40, 0, 32'h0,        0, 1, 32'h5678,     0};
    vecs[13] = '{1, 32'h100, 1, 0, 4'hF, 32'h200,   32'h0,        0, 1, 1, 32'h80, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0};
    vecs[14] = '{0, 32'h0,   0, 0, 4'h0, 32'h0,     32'h0,        0, 0, 0, 32'h0,  0, 32'h0,        0, 1, 32'h5678,     0};

    rst_sys_n = 1'b0;
    set_idle();
    repeat (3) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1;

    // Idle after reset release
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_sys);
      chk($sformatf("idle%0d gnt", c), {30'h0, instr_gnt, data_gnt}, 32'h0);
      chk($sformatf("idle%0d rv_err", c),
          {28'h0, instr_rvalid, data_rvalid, instr_err, data_err}, 32'h0);
      chk($sformatf("idle%0d mem_req", c), {31'h0, mem_req}, 32'h0);
    end

    // Per-cycle vector table
    for (int i = 0; i < 15; i++) begin
      @(posedge clk_sys);
      #1;
      instr_req  = vecs[i].ireq;  instr_addr = vecs[i].iaddr;
      data_req   = vecs[i].dreq;  data_we    = vecs[i].dwe;
      data_be    = vecs[i].dbe;   data_addr  = vecs[i].daddr;
      data_wdata = vecs[i].dwdata;
      @(negedge clk_sys);
      chk($sformatf("v%0d instr_gnt", i), {31'h0, instr_gnt}, {31'h0, vecs[i].igt});
      chk($sformatf("v%0d data_gnt", i), {31'h0, data_gnt}, {31'h0, vecs[i].dgt});
      chk($sformatf("v%0d mem_req", i), {31'h0, mem_req}, {31'h0, vecs[i].mreq});
      chk($sformatf("v%0d mem_addr", i), mem_addr, vecs[i].maddr);
      chk($sformatf("v%0d instr_rvalid", i), {31'h0, instr_rvalid}, {31'h0, vecs[i].irv});
      chk($sformatf("v%0d instr_rdata", i), instr_rdata, vecs[i].irdata);
      chk($sformatf("v%0d instr_err", i), {31'h0, instr_err}, {31'h0, vecs[i].ierr});
      chk($sformatf("v%0d data_rvalid", i), {31'h0, data_rvalid}, {31'h0, vecs[i].drv});
      chk($sformatf("v%0d data_rdata", i), data_rdata, vecs[i].drdata);
      chk($sformatf("v%0d data_err", i), {31'h0, data_err}, {31'h0, vecs[i].derr});
    end

    // Fetch granted, then reset before its response cycle
    @(posedge clk_sys);
    #1 set_idle(); instr_req = 1'b1; instr_addr = 32'h100;
    @(negedge clk_sys);
    chk("rst fetch gnt", {31'h0, instr_gnt}, 32'h1);
    @(posedge clk_sys);
    #1 rst_sys_n = 1'b0;
    @(negedge clk_sys);
    chk("in rst instr_gnt", {31'h0, instr_gnt}, 32'h0);
    chk("in rst instr_rvalid", {31'h0, instr_rvalid}, 32'h0);
    chk("in rst instr_rdata", instr_rdata, 32'h0);
    chk("in rst mem_req", {31'h0, mem_req}, 32'h0);
    repeat (2) @(posedge clk_sys);
    #1 rst_sys_n = 1'b1; instr_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_sys);
      chk($sformatf("post rst%0d rvalid", c), {30'h0, instr_rvalid, data_rvalid}, 32'h0);
    end
    @(posedge clk_sys);
    #1 instr_req = 1'b1; instr_addr = 32'h100;
    @(negedge clk_sys);
    chk("post rst fetch gnt", {31'h0, instr_gnt}, 32'h1);
    chk("post rst fetch mem_addr", mem_addr, 32'h40);
    @(posedge clk_sys);
    #1 instr_req = 1'b0;
    @(negedge clk_sys);
    chk("post rst fetch rvalid", {31'h0, instr_rvalid}, 32'h1);
    chk("post rst fetch rdata", instr_rdata, 32'hDEAD_BEEF);
    chk("post rst fetch err", {31'h0, instr_err}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
